// File: rtl/adder_core_pkg.sv
// Shared constants and the full-adder bit equation for the adder_core ripple chain.
package adder_core_pkg;

    localparam int ADDER_N_DEFAULT = 21;
    localparam int ADDER_N_MIN     = 1;
    localparam int ADDER_N_MAX     = 64;

    typedef struct packed {
        logic s;
        logic cout;
    } fa_out_t;

    // One bit of the ripple chain, written as the explicit sum/carry equations.
    function automatic fa_out_t fa_eval(input logic a, input logic b, input logic cin);
        fa_out_t r;
        r.s    = a ^ b ^ cin;
        r.cout = (a & b) | (cin & (a ^ b));
        return r;
    endfunction

endpackage

// File: rtl/adder_core_if.sv
// Operand/result bundle between the flit-injection stimulus and adder_core.
interface adder_core_if #(
    parameter int N = 21
);
    logic [N-1:0] input1;
    logic [N-1:0] input2;
    logic [N-1:0] sum;

    modport master (output input1, output input2, input sum);
    modport slave  (input input1, input input2, output sum);
endinterface

// File: rtl/adder_core_full_adder_cell.sv
// Single full-adder cell; one instance per bit of the ripple chain.
module full_adder_cell
    import adder_core_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    fa_out_t r;

    assign r    = fa_eval(a, b, cin);
    assign s    = r.s;
    assign cout = r.cout;
endmodule

// File: rtl/adder_core.sv
// Registered N-bit unsigned adder: explicit ripple-carry chain feeding one sum register.
module adder_core
    import adder_core_pkg::*;
#(
    parameter int N = ADDER_N_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    adder_core_if.slave bus
);
    generate
        if (N < ADDER_N_MIN || N > ADDER_N_MAX) begin : g_bad_width
            $error("adder_core: N out of range");
        end
    endgenerate

    logic [N-1:0] carry_p0;
    logic [N-1:0] s_p0;
    logic         carry_unused;

    assign carry_p0[0] = 1'b0;

    // Stage p0: combinational ripple chain, LSB first; final carry-out is dropped.
    generate
        for (genvar i = 0; i < N; i++) begin : g_bit
            logic cout;

            full_adder_cell u_fa (
                .a    (bus.input1[i]),
                .b    (bus.input2[i]),
                .cin  (carry_p0[i]),
                .s    (s_p0[i]),
                .cout (cout)
            );

            if (i < N - 1) begin : g_link
                assign carry_p0[i+1] = cout;
            end else begin : g_last
                assign carry_unused = cout;
            end
        end
    endgenerate

    // Stage p1: the only state in the block, reset has priority over the add.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.sum <= '0;
        end else begin
            bus.sum <= s_p0;
        end
    end
endmodule

// File: tb/tb_adder_core.sv
// Scoreboard bench for adder_core: expected sums queued at drive time, popped after each edge.
module tb_adder_core;
    localparam int N = 21;
    localparam logic [63:0] MASK = (64'd1 << N) - 64'd1;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;
    logic [N-1:0] sb_q[$];
    logic [N-1:0] last_exp;

    adder_core_if #(.N(N)) bus ();

    adder_core #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%06h expected 0x%06h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [N-1:0] model_sum(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [63:0] full;
        full = 64'(a) + 64'(b);
        return N'(full & MASK);
    endfunction

    // Drive one cycle at negedge, optionally confirm sum has not moved yet, then check after the edge.
    task automatic step(input string tag, input logic r, input logic [N-1:0] a,
                        input logic [N-1:0] b, input bit pre_check);
        logic [N-1:0] e;
        @(negedge clk);
        rst        = r;
        bus.input1 = a;
        bus.input2 = b;
        sb_q.push_back(r ? '0 : model_sum(a, b));
        if (pre_check) begin
            #1;
            check_val({tag, "_before"}, bus.sum, last_exp);
        end
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check_val({tag, "_empty"}, bus.sum, 'x);
        end else begin
            e = sb_q.pop_front();
            check_val(tag, bus.sum, e);
            last_exp = e;
        end
    endtask

    initial begin
        logic [N-1:0] a;
        logic [N-1:0] b;
        n_checks = 0;
        n_pass   = 0;
        rst        = 1'b1;
        bus.input1 = '0;
        bus.input2 = '0;
        last_exp   = '0;

        step("reset0", 1'b1, 21'h1FFFFF, 21'h000001, 1'b0);
        step("reset1", 1'b1, 21'h1FFFFF, 21'h000001, 1'b0);

        step("latency", 1'b0, 21'h000000, 21'h1FE000, 1'b1);

        step("wrap_hi",  1'b0, 21'h1C0000, 21'h1FFFFF, 1'b1);
        step("wrap_all", 1'b0, 21'h1FFFFF, 21'h000001, 1'b1);

        step("b2b_0", 1'b0, 21'h000000, 21'h1FFFE0, 1'b0);
        step("b2b_1", 1'b0, 21'h0003FF, 21'h1FFFFF, 1'b0);
        step("b2b_2", 1'b0, 21'h000000, 21'h000000, 1'b0);

        step("mid_pre",   1'b0, 21'h0ABCDE, 21'h012345, 1'b0);
        step("mid_rst",   1'b1, 21'h055555, 21'h0AAAAA, 1'b0);
        step("mid_after", 1'b0, 21'h055555, 21'h0AAAAA, 1'b0);

        a = '0;
        b = '0;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 7) != 0) begin
                a = N'($urandom);
                b = N'($urandom);
            end
            step("random", 1'b0, a, b, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
